vect_store_serializer: RTL and testbench

Write-back serializer for the SIMD audio datapath: accepts one M-lane × N-bit result vector from the vector ALU stage and emits its enabled lanes, one lane per beat, as scalar (address, sample) writes toward data memory or the audio output path. It is the consumer end of the vector-result interface, converting a parallel lane vector into a masked, addressed byte stream. Valid/ready handshakes on both sides give full-rate back-to-back operation with backpressure.

---
 rtl/vect_store_serializer_pkg.sv | 17 +
 rtl/vect_store_serializer_lane_next_set.sv | 30 +++
 rtl/vect_store_serializer.sv | 185 ++++++++++++++++++
 tb/tb_vect_store_serializer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vect_store_serializer_pkg.sv
// Shared types for the vector write-back serializer: default geometry,
// lane/vector typedefs and the serializer state encoding.
package vect_pkg;

   localparam int N_DEF      = 8;
   localparam int M_DEF      = 16;
   localparam int ADDR_W_DEF = 16;

   typedef logic signed [N_DEF-1:0] lane_t;
   typedef lane_t [0:M_DEF-1]       vec_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/vect_store_serializer_lane_next_set.sv
// Priority encoder: lowest set mask index that is >= start, plus a found flag.
// start is one bit wider than an index so "past the last lane" is expressible.
module lane_next_set
   import vect_pkg::*;
#(
   parameter int M     = M_DEF,
   parameter int IDX_W = 4
) (
   input  logic [0:M-1]     mask,
   input  logic [IDX_W:0]   start,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan downwards so the lowest qualifying lane is the one left standing
   always_comb begin
      idx   = {IDX_W{1'b0}};
      found = 1'b0;
      for (int i = M - 1; i >= 0; i--) begin
         if (mask[i] && (i >= int'(start))) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end else begin
            idx   = idx;
            found = found;
         end
      end
   end

endmodule

// File: rtl/vect_store_serializer.sv
// Write-back serializer: holds one masked lane vector and emits its enabled
// lanes as (address, sample) beats, one per cycle, with valid/ready on both sides.
module vect_store_serializer
   import vect_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int M      = M_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [0:M-1][N-1:0] in_data,
   input  logic [ADDR_W-1:0]          in_base_addr,
   input  logic [0:M-1]               in_mask,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [N-1:0]        out_data,
   output logic [ADDR_W-1:0]          out_addr,
   output logic                       out_last,
   output logic                       busy
);

   localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

   state_t                  state_r;
   state_t                  state_n_s;
   logic [IDX_W-1:0]        ptr_r;
   logic [IDX_W-1:0]        ptr_n_s;
   logic [0:M-1][N-1:0]     data_r;
   logic [ADDR_W-1:0]       base_r;
   logic [0:M-1]            mask_r;

   logic                    out_valid_r;
   logic signed [N-1:0]     out_data_r;
   logic [ADDR_W-1:0]       out_addr_r;
   logic                    out_last_r;

   logic                    beat_s;
   logic                    final_s;
   logic                    ready_s;
   logic                    accept_s;

   logic [IDX_W-1:0]        load_idx_s;
   logic                    load_found_s;
   logic [IDX_W:0]          adv_start_s;
   logic [IDX_W-1:0]        adv_idx_s;
   logic                    adv_found_s;

   logic [0:M-1][N-1:0]     eff_data_s;
   logic [ADDR_W-1:0]       eff_base_s;
   logic [0:M-1]            eff_mask_s;
   logic                    last_n_s;
   logic [N-1:0]            data_n_s;
   logic [ADDR_W-1:0]       addr_n_s;

   // Handshake qualifiers; in_ready opens on the final beat so vectors chain gap-free
   always_comb begin
      beat_s   = (state_r == SEND) && out_ready;
      final_s  = beat_s && out_last_r;
      ready_s  = !rst && ((state_r == IDLE) || final_s);
      accept_s = in_valid && ready_s;
   end

   assign adv_start_s = (IDX_W+1)'(ptr_r) + (IDX_W+1)'(1);

   lane_next_set #(.M(M), .IDX_W(IDX_W)) u_load_enc (
      .mask  (in_mask),
      .start ({(IDX_W+1){1'b0}}),
      .idx   (load_idx_s),
      .found (load_found_s)
   );

   lane_next_set #(.M(M), .IDX_W(IDX_W)) u_adv_enc (
      .mask  (mask_r),
      .start (adv_start_s),
      .idx   (adv_idx_s),
      .found (adv_found_s)
   );

   // Next state and lane pointer; an all-zero mask is absorbed without leaving IDLE
   always_comb begin
      state_n_s = state_r;
      ptr_n_s   = ptr_r;
      case (state_r)
         IDLE: begin
            if (accept_s && load_found_s) begin
               state_n_s = SEND;
               ptr_n_s   = load_idx_s;
            end else begin
               state_n_s = IDLE;
            end
         end
         SEND: begin
            if (beat_s && !out_last_r && adv_found_s) begin
               ptr_n_s = adv_idx_s;
            end else if (beat_s) begin
               if (accept_s && load_found_s) begin
                  state_n_s = SEND;
                  ptr_n_s   = load_idx_s;
               end else begin
                  state_n_s = IDLE;
               end
            end else begin
               state_n_s = SEND;
            end
         end
         default: begin
            state_n_s = IDLE;
            ptr_n_s   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Beat source is the incoming vector on a load, otherwise the held one
   always_comb begin
      if (accept_s) begin
         eff_data_s = in_data;
         eff_base_s = in_base_addr;
         eff_mask_s = in_mask;
      end else begin
         eff_data_s = data_r;
         eff_base_s = base_r;
         eff_mask_s = mask_r;
      end
      last_n_s = 1'b1;
      for (int i = 0; i < M; i++) begin
         last_n_s = last_n_s & !(eff_mask_s[i] && (i > int'(ptr_n_s)));
      end
      data_n_s = eff_data_s[ptr_n_s];
      addr_n_s = eff_base_s + ADDR_W'(ptr_n_s);
   end

   // State, pointer and vector holding registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r   <= {IDX_W{1'b0}};
         data_r  <= {(M*N){1'b0}};
         base_r  <= {ADDR_W{1'b0}};
         mask_r  <= {M{1'b0}};
      end else begin
         state_r <= state_n_s;
         ptr_r   <= ptr_n_s;
         if (accept_s) begin
            data_r <= in_data;
            base_r <= in_base_addr;
            mask_r <= in_mask;
         end else begin
            data_r <= data_r;
            base_r <= base_r;
            mask_r <= mask_r;
         end
      end
   end

   // Registered beat outputs; data/address hold while stalled or idle
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_data_r  <= {N{1'b0}};
         out_addr_r  <= {ADDR_W{1'b0}};
         out_last_r  <= 1'b0;
      end else if (state_n_s == SEND) begin
         out_valid_r <= 1'b1;
         out_data_r  <= data_n_s;
         out_addr_r  <= addr_n_s;
         out_last_r  <= last_n_s;
      end else begin
         out_valid_r <= 1'b0;
         out_data_r  <= out_data_r;
         out_addr_r  <= out_addr_r;
         out_last_r  <= 1'b0;
      end
   end

   assign in_ready  = ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_addr  = out_addr_r;
   assign out_last  = out_last_r;
   assign busy      = (state_r == SEND);

endmodule

// File: tb/tb_vect_store_serializer.sv
// Bench for vect_store_serializer: directed and random vectors checked beat by
// beat against a queue of expected (address, sample, last) writes.
module tb_vect_store_serializer;

   localparam int N  = 8;
   localparam int M  = 16;
   localparam int AW = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic                in_ready;
   logic [0:M-1][N-1:0] in_data;
   logic [AW-1:0]       in_base_addr;
   logic [0:M-1]        in_mask;
   logic                out_valid;
   logic                out_ready;
   logic [N-1:0]        out_data;
   logic [AW-1:0]       out_addr;
   logic                out_last;
   logic                busy;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [N-1:0]  data;
      logic          last;
   } beat_t;

   beat_t q[$];
   int    n_chk  = 0;
   int    n_fail = 0;
   int    mode   = 0;
   int    bp_cnt = 0;
   int    cyc    = 0;
   int    pops   = 0;

   always #5 clk = ~clk;

   vect_store_serializer #(.N(N), .M(M), .ADDR_W(AW)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_base_addr (in_base_addr),
      .in_mask      (in_mask),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_addr     (out_addr),
      .out_last     (out_last),
      .busy         (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected writes: every enabled lane in ascending order, last on the highest one
   function automatic void model_accept(logic [0:M-1][N-1:0] d, logic [AW-1:0] b, logic [0:M-1] m);
      int hi = -1;
      beat_t e;
      for (int i = 0; i < M; i++) if (m[i]) hi = i;
      for (int i = 0; i < M; i++) begin
         if (m[i]) begin
            e.addr = b + AW'(i);
            e.data = d[i];
            e.last = (i == hi);
            q.push_back(e);
         end
      end
   endfunction

   function automatic logic ordy_gen();
      int k;
      if (mode == 0) return 1'b1;
      if (mode == 1) begin
         k = bp_cnt % 4;
         bp_cnt++;
         return (k == 0) || (k == 3);
      end
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [0:M-1][N-1:0] rand_vec();
      logic [0:M-1][N-1:0] v;
      for (int i = 0; i < M; i++) v[i] = N'($urandom);
      return v;
   endfunction

   // One clock cycle: drive, check outputs against the model, then advance
   task automatic step(input logic r, input logic v, output logic acc);
      logic o, er;
      o = r ? 1'b0 : ordy_gen();
      rst = r; in_valid = v; out_ready = o;
      #1;
      er = !r && ((q.size() == 0) || (o && q.size() == 1));
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, q.size() > 0);
      chk("busy", busy, q.size() > 0);
      if (q.size() > 0) begin
         chk("out_addr", out_addr, q[0].addr);
         chk("out_data", out_data, q[0].data);
         chk("out_last", out_last, q[0].last);
         if (o) begin
            void'(q.pop_front());
            pops++;
         end
      end
      acc = v && er;
      if (acc) model_accept(in_data, in_base_addr, in_mask);
      @(posedge clk);
      if (r) q.delete();
      cyc++;
      #1;
   endtask

   task automatic offer(input logic [0:M-1][N-1:0] d, input logic [AW-1:0] b, input logic [0:M-1] m);
      logic acc = 1'b0;
      int   t   = 0;
      in_data = d; in_base_addr = b; in_mask = m;
      while (!acc && t < 200) begin
         step(1'b0, 1'b1, acc);
         t++;
      end
      chk("offer_accepted", acc, 1'b1);
   endtask

   task automatic drain();
      logic acc;
      int   t = 0;
      while (q.size() > 0 && t < 300) begin
         in_data = rand_vec(); in_base_addr = AW'($urandom); in_mask = M'($urandom);
         step(1'b0, 1'b0, acc);
         t++;
      end
      chk("drain_done", q.size(), 0);
   endtask

   initial begin
      logic [0:M-1][N-1:0] d;
      logic [0:M-1]        m;
      logic                acc;
      int                  c0, p0;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_data = rand_vec(); in_base_addr = 16'h0000; in_mask = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_addr", out_addr, 16'h0000);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      step(1'b0, 1'b0, acc);

      // Full mask, ramp data
      for (int i = 0; i < M; i++) d[i] = N'(i);
      p0 = pops;
      offer(d, 16'h0100, 16'hFFFF);
      c0 = cyc;
      drain();
      chk("full_cycles", cyc - c0, 16);
      chk("full_beats", pops - p0, 16);

      // Sparse mask: lanes 0, 5, 15
      m = 16'h0000; m[0] = 1'b1; m[5] = 1'b1; m[15] = 1'b1;
      p0 = pops;
      offer(rand_vec(), 16'h0200, m);
      c0 = cyc;
      drain();
      chk("sparse_cycles", cyc - c0, 3);
      chk("sparse_beats", pops - p0, 3);

      // Backpressure pattern 1,0,0,1
      mode = 1; bp_cnt = 0;
      offer(rand_vec(), 16'h0400, 16'hFFFF);
      drain();
      mode = 0;

      // Address wrap
      offer(rand_vec(), 16'hFFF8, 16'hFFFF);
      drain();

      // Back-to-back full vectors
      p0 = pops;
      offer(rand_vec(), 16'h1000, 16'hFFFF);
      c0 = cyc;
      offer(rand_vec(), 16'h2000, 16'hFFFF);
      drain();
      chk("b2b_cycles", cyc - c0, 32);
      chk("b2b_beats", pops - p0, 32);

      // Zero-mask vector sandwiched between two full vectors
      p0 = pops;
      offer(rand_vec(), 16'h3000, 16'hFFFF);
      offer(rand_vec(), 16'h3100, 16'h0000);
      offer(rand_vec(), 16'h3200, 16'hFFFF);
      drain();
      chk("zero_mask_beats", pops - p0, 32);

      // Random vectors, random masks, random backpressure
      mode = 2;
      for (int k = 0; k < 12; k++) begin
         m = M'($urandom);
         if (k == 3) m = 16'h0000;
         if (k == 7) m = 16'h0001;
         if (k == 9) m = 16'h8000;
         offer(rand_vec(), AW'($urandom), m);
      end
      drain();
      mode = 0;

      // Reset after five beats of a full vector
      offer(rand_vec(), 16'h0500, 16'hFFFF);
      repeat (5) step(1'b0, 1'b0, acc);
      step(1'b1, 1'b0, acc);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_out_last", out_last, 1'b0);
      chk("midrst_out_data", out_data, 8'h00);
      chk("midrst_out_addr", out_addr, 16'h0000);
      step(1'b0, 1'b0, acc);
      for (int i = 0; i < M; i++) d[i] = N'(8'hA0 + i);
      offer(d, 16'h0600, 16'hFFFF);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
